// File: rtl/adc_pkg.sv
// Shared constants and FSM encoding for the serial ADC capture front-end.
package adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A frame is well-formed when its leading bits are all zero.
    function automatic logic lead_ok(input logic [FRAME_BITS-1:0] frame);
        return (frame[FRAME_BITS-1 -: LEAD_BITS] == '0);
    endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// SPI master for one ADC frame: drives CS_N/SCLK, shifts in SDATA on every
// SCLK rising edge, and pulses done_o the cycle CS_N returns high.
module adc_spi_shifter
    import adc_pkg::*;
#(
    parameter int SCLK_DIV = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  sdata_i,
    output logic                  cs_n_o,
    output logic                  sclk_o,
    output logic                  done_o,
    output logic [FRAME_BITS-1:0] shift_o
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic                  active_q, active_d;
    logic                  last_q,   last_d;
    logic                  done_q,   done_d;
    logic                  cs_n_q,   cs_n_d;
    logic                  sclk_q,   sclk_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [FRAME_BITS-1:0] shift_q,  shift_d;

    // Next-state: last_q marks the cycle after the final rising edge, where CS_N is released.
    always_comb begin
        active_d = active_q;
        last_d   = 1'b0;
        done_d   = 1'b0;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (last_q) begin
            active_d = 1'b0;
            cs_n_d   = 1'b1;
            sclk_d   = 1'b1;
            done_d   = 1'b1;
        end else if (active_q) begin
            if (div_q == DIV_W'(SCLK_DIV - 1)) begin
                div_d  = '0;
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], sdata_i};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        last_d = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if (start_i) begin
            active_d = 1'b1;
            cs_n_d   = 1'b0;
            sclk_d   = 1'b1;
            div_d    = '0;
            bit_d    = '0;
        end
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            active_q <= active_d;
            last_q   <= last_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    assign cs_n_o  = cs_n_q;
    assign sclk_o  = sclk_q;
    assign done_o  = done_q;
    assign shift_o = shift_q;

endmodule

// File: rtl/adc_spi_capture.sv
// Periodic 12-bit serial ADC capture with lead-bit checking and 2^AVG_LOG2
// sample averaging; feeds the seven-segment display driver.
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int SCLK_DIV      = 25,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int AVG_LOG2      = 2
) (
    input  logic                 Sys_CLK,
    input  logic                 Sys_RST,
    input  logic                 Start_EN,
    input  logic                 ADC_SDATA,
    output logic                 ADC_CS_N,
    output logic                 ADC_SCLK,
    output logic [DATA_BITS-1:0] Data_Bin,
    output logic                 Data_Valid,
    output logic                 EN,
    output logic                 Frame_Err
);

    localparam int TMR_W = $clog2(SAMPLE_PERIOD);
    localparam int ACC_W = DATA_BITS + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    // Truncating divide of the accumulated sum by the sample count.
    function automatic logic [DATA_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] shifted;
        shifted = sum >> AVG_LOG2;
        return shifted[DATA_BITS-1:0];
    endfunction

    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  tick;
    state_t                state_q, state_d;
    logic                  start;
    logic                  shift_done;
    logic [FRAME_BITS-1:0] shift_w;
    logic [ACC_W-1:0]      sum_w;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  data_bin_q, data_bin_d;
    logic                  valid_q, valid_d;
    logic                  en_q, en_d;
    logic                  ferr_q, ferr_d;

    adc_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk_i   (Sys_CLK),
        .rst_i   (Sys_RST),
        .start_i (start),
        .sdata_i (ADC_SDATA),
        .cs_n_o  (ADC_CS_N),
        .sclk_o  (ADC_SCLK),
        .done_o  (shift_done),
        .shift_o (shift_w)
    );

    assign tick  = Start_EN && (timer_q == TMR_W'(SAMPLE_PERIOD - 1));
    assign sum_w = acc_q + ACC_W'(shift_w[DATA_BITS-1:0]);

    // Sample timer: parked at zero while disabled, wraps on the tick.
    always_comb begin
        timer_d = timer_q + 1'b1;
        if (!Start_EN || tick) begin
            timer_d = '0;
        end
    end

    // Conversion sequencer; ticks arriving outside IDLE are ignored.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_CONV;
                    start   = 1'b1;
                end
            end
            ST_CONV: begin
                if (shift_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame disposition: check lead bits, accumulate good samples, publish averages.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        data_bin_d = data_bin_q;
        valid_d    = 1'b0;
        en_d       = en_q;
        ferr_d     = 1'b0;
        if (!Start_EN) begin
            en_d = 1'b0;
        end
        if (state_q == ST_CONV && shift_done) begin
            if (!lead_ok(shift_w)) begin
                ferr_d = 1'b1;
            end
            if (!Start_EN) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (lead_ok(shift_w)) begin
                if (cnt_q == CNT_LAST) begin
                    data_bin_d = avg_trunc(sum_w);
                    valid_d    = 1'b1;
                    en_d       = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                end else begin
                    acc_d = sum_w;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Registers for timer, FSM, accumulator and outputs.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            timer_q    <= '0;
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            data_bin_q <= '0;
            valid_q    <= 1'b0;
            en_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            data_bin_q <= data_bin_d;
            valid_q    <= valid_d;
            en_q       <= en_d;
            ferr_q     <= ferr_d;
        end
    end

    assign Data_Bin   = data_bin_q;
    assign Data_Valid = valid_q;
    assign EN         = en_q;
    assign Frame_Err  = ferr_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: behavioural ADC, event monitors and directed
// plus randomized frame groups checked against an averaging model.
module tb_adc_spi_capture;

    localparam int SCLK_DIV      = 2;
    localparam int SAMPLE_PERIOD = 100;
    localparam int AVG_LOG2      = 2;
    localparam int CS_LOW_CYC    = 32 * SCLK_DIV + 1;
    localparam int VALID_LAT     = 32 * SCLK_DIV + 2;

    logic        Sys_CLK;
    logic        Sys_RST;
    logic        Start_EN;
    logic        ADC_SDATA;
    logic        ADC_CS_N;
    logic        ADC_SCLK;
    logic [11:0] Data_Bin;
    logic        Data_Valid;
    logic        EN;
    logic        Frame_Err;

    adc_spi_capture #(
        .SCLK_DIV      (SCLK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .AVG_LOG2      (AVG_LOG2)
    ) dut (
        .Sys_CLK    (Sys_CLK),
        .Sys_RST    (Sys_RST),
        .Start_EN   (Start_EN),
        .ADC_SDATA  (ADC_SDATA),
        .ADC_CS_N   (ADC_CS_N),
        .ADC_SCLK   (ADC_SCLK),
        .Data_Bin   (Data_Bin),
        .Data_Valid (Data_Valid),
        .EN         (EN),
        .Frame_Err  (Frame_Err)
    );

    initial begin
        Sys_CLK = 1'b0;
        forever #5 Sys_CLK = ~Sys_CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Frames the ADC will return, one per CS_N falling edge (zero if empty).
    logic [15:0] frame_q[$];
    logic [15:0] grp[$];

    int cyc = 0;
    int cs_falls = 0;
    int cs_len = 0;
    int t0_cyc = 0;
    int valid_cnt = 0;
    int valid_lat = 0;
    int falls_at_valid = 0;
    int ferr_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // ADC model plus event monitors, evaluated on the falling clock edge.
    initial begin
        logic        prev_cs;
        logic        prev_sclk;
        logic [15:0] cur;
        int          idx;
        int          run;
        prev_cs   = 1'b1;
        prev_sclk = 1'b1;
        cur       = '0;
        idx       = 16;
        run       = 0;
        ADC_SDATA = 1'b0;
        forever begin
            @(negedge Sys_CLK);
            cyc++;
            if (prev_cs && !ADC_CS_N) begin
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                else cur = 16'h0000;
                idx       = 16;
                ADC_SDATA = 1'b0;
                cs_falls++;
                t0_cyc = cyc;
            end else if (!ADC_CS_N && prev_sclk && !ADC_SCLK && idx > 0) begin
                idx--;
                ADC_SDATA = cur[idx];
            end else if (ADC_CS_N) begin
                ADC_SDATA = 1'b0;
            end
            if (!ADC_CS_N) begin
                run++;
            end else if (!prev_cs) begin
                cs_len = run;
                run    = 0;
            end
            if (Data_Valid) begin
                valid_cnt++;
                valid_lat      = cyc - t0_cyc;
                falls_at_valid = cs_falls;
            end
            if (Frame_Err) ferr_cnt++;
            prev_cs   = ADC_CS_N;
            prev_sclk = ADC_SCLK;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Sys_CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < budget && valid_cnt == v0; i++) step(1);
        check({tag, "_valid_seen"}, 32'(valid_cnt != v0), 32'd1);
    endtask

    task automatic wait_fall(input string tag, input int budget);
        int f0;
        f0 = cs_falls;
        for (int i = 0; i < budget && cs_falls == f0; i++) step(1);
        check({tag, "_cs_fall_seen"}, 32'(cs_falls != f0), 32'd1);
    endtask

    // Reference: the first four frames with zero lead bits are averaged (truncating);
    // every bad frame before that point is reported once.
    task automatic model(output logic [11:0] exp_bin, output int exp_err, output int used);
        int sum;
        int good;
        sum = 0; good = 0; used = 0; exp_err = 0;
        foreach (grp[i]) begin
            if (good < 4) begin
                used++;
                if (grp[i][15:12] == 4'h0) begin
                    sum += int'(grp[i][11:0]);
                    good++;
                end else begin
                    exp_err++;
                end
            end
        end
        exp_bin = 12'(sum / 4);
    endtask

    task automatic run_group(input string tag);
        logic [11:0] exp_bin;
        int exp_err, used, v0, e0, f0;
        model(exp_bin, exp_err, used);
        v0 = valid_cnt; e0 = ferr_cnt; f0 = cs_falls;
        for (int i = 0; i < used; i++) frame_q.push_back(grp[i]);
        wait_valid(tag, (used + 2) * SAMPLE_PERIOD + 100);
        check({tag, "_data_bin"}, 32'(Data_Bin), 32'(exp_bin));
        check({tag, "_valid_hi"}, 32'(Data_Valid), 32'd1);
        check({tag, "_en"}, 32'(EN), 32'd1);
        check({tag, "_valid_count"}, 32'(valid_cnt - v0), 32'd1);
        check({tag, "_frame_err_count"}, 32'(ferr_cnt - e0), 32'(exp_err));
        check({tag, "_frames_used"}, 32'(falls_at_valid - f0), 32'(used));
        check({tag, "_valid_latency"}, 32'(valid_lat), 32'(VALID_LAT));
        check({tag, "_cs_low_cycles"}, 32'(cs_len), 32'(CS_LOW_CYC));
        step(1);
        check({tag, "_valid_pulse_width"}, 32'(Data_Valid), 32'd0);
        grp.delete();
    endtask

    function automatic logic [15:0] rnd_good();
        return {4'h0, 12'($urandom_range(0, 4095))};
    endfunction

    initial begin
        int          good;
        int          v0, f0, e0;
        logic [11:0] held;

        Sys_RST  = 1'b1;
        Start_EN = 1'b0;

        // Reset state
        step(3);
        check("rst_cs_n", 32'(ADC_CS_N), 32'd1);
        check("rst_sclk", 32'(ADC_SCLK), 32'd1);
        check("rst_data_bin", 32'(Data_Bin), 32'd0);
        check("rst_en", 32'(EN), 32'd0);
        check("rst_valid", 32'(Data_Valid), 32'd0);
        check("rst_frame_err", 32'(Frame_Err), 32'd0);
        Sys_RST = 1'b0;
        step(2);
        check("idle_cs_n", 32'(ADC_CS_N), 32'd1);
        Start_EN = 1'b1;

        // Constant sample
        repeat (4) grp.push_back(16'h0ABC);
        run_group("const_abc");

        // Truncating average
        grp.push_back(16'h0001); grp.push_back(16'h0002);
        grp.push_back(16'h0003); grp.push_back(16'h0004);
        run_group("trunc_1234");

        // Random good groups, including extremes
        for (int r = 0; r < 3; r++) begin
            repeat (4) grp.push_back(rnd_good());
            run_group($sformatf("rand_good%0d", r));
        end
        repeat (4) grp.push_back(16'h0FFF);
        run_group("max_fff");

        // Bad lead bits in the middle of an average
        grp.push_back(16'h0100); grp.push_back(16'h1FFF);
        grp.push_back(16'h0100); grp.push_back(16'h0100); grp.push_back(16'h0100);
        run_group("bad_lead_fixed");

        for (int r = 0; r < 2; r++) begin
            good = 0;
            while (good < 4) begin
                if ($urandom_range(0, 2) == 0) begin
                    grp.push_back({4'($urandom_range(1, 15)), 12'($urandom_range(0, 4095))});
                end else begin
                    grp.push_back(rnd_good());
                    good++;
                end
            end
            run_group($sformatf("rand_bad%0d", r));
        end

        // Start_EN dropped mid-frame
        held = Data_Bin;
        v0 = valid_cnt; e0 = ferr_cnt;
        f0 = cs_falls;
        frame_q.push_back(rnd_good());
        wait_fall("stop", 2 * SAMPLE_PERIOD);
        check("stop_en_before", 32'(EN), 32'd1);
        step(31);
        Start_EN = 1'b0;
        step(1);
        check("stop_en_after", 32'(EN), 32'd0);
        check("stop_cs_still_low", 32'(ADC_CS_N), 32'd0);
        for (int i = 0; i < 200 && ADC_CS_N == 1'b0; i++) step(1);
        check("stop_cs_low_cycles", 32'(cs_len), 32'(CS_LOW_CYC));
        step(3 * SAMPLE_PERIOD);
        check("stop_no_new_frames", 32'(cs_falls - f0), 32'd1);
        check("stop_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("stop_no_frame_err", 32'(ferr_cnt - e0), 32'd0);
        check("stop_data_held", 32'(Data_Bin), 32'(held));
        check("stop_en_held_low", 32'(EN), 32'd0);
        frame_q.delete();
        Start_EN = 1'b1;
        repeat (4) grp.push_back(rnd_good());
        run_group("reenable");

        // Reset mid-frame
        v0 = valid_cnt;
        frame_q.push_back(rnd_good());
        wait_fall("midrst", 2 * SAMPLE_PERIOD);
        step(19);
        check("midrst_cs_low_before", 32'(ADC_CS_N), 32'd0);
        Sys_RST = 1'b1;
        step(1);
        check("midrst_cs_n", 32'(ADC_CS_N), 32'd1);
        check("midrst_sclk", 32'(ADC_SCLK), 32'd1);
        check("midrst_data_bin", 32'(Data_Bin), 32'd0);
        check("midrst_en", 32'(EN), 32'd0);
        step(2);
        Start_EN = 1'b0;
        Sys_RST  = 1'b0;
        step(150);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_cs_idle", 32'(ADC_CS_N), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
